// File: rtl/difftest_step_pkg.sv
// Shared types and helpers for the difftest step batching logic.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package difftest_step_pkg;

  // Batcher lifecycle: normal operation, one-cycle exit gap, terminal.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXIT_WAIT = 2'd1,
    EXITED    = 2'd2
  } state_e;

  // Exit code the core reports on a clean finish.
  localparam logic [63:0] EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

  // Number of set bits in a vector of up to 32 commit strobes.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/difftest_commit_popcount.sv
// Counts how many commit slots fired this cycle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; every slot is counted every cycle.
module difftest_commit_popcount
  import difftest_step_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_W     = $clog2(NUM_PORTS + 1)
) (
  input  logic [NUM_PORTS-1:0] valid_i,
  output logic [CNT_W-1:0]     count_o
);

  // Slots beyond 32 would be silently dropped by the helper.
  if (NUM_PORTS > 32) begin : g_bad_ports
    $error("difftest_commit_popcount: NUM_PORTS must not exceed 32");
  end

  // Zero-extend the strobes and reduce them to a count.
  always_comb begin
    count_o = CNT_W'(popcount32(32'(valid_i)));
  end

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into multi-instruction step requests for the difftest endpoint.
// Latency: all outputs registered; decisions on cycle-N inputs show in cycle N+1, exit code one cycle after the final step.
// Backpressure: none; commits are counted every cycle and flushed on threshold, timeout, flush, disable or exit.
module difftest_step_batcher
  import difftest_step_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned STEP_WIDTH = 8,
  parameter int unsigned BATCH      = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_PORTS-1:0]  commit_valid,
  input  logic                  flush_req,
  input  logic [63:0]           exit_in,
  output logic [STEP_WIDTH-1:0] step_out,
  output logic [63:0]           exit_out,
  output logic [STEP_WIDTH-1:0] pending,
  output logic                  exited
);

  localparam int unsigned CNT_W = $clog2(NUM_PORTS + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [STEP_WIDTH:0] BATCH_L  = (STEP_WIDTH + 1)'(BATCH);

  // The largest possible emitted sum must fit in step_out.
  if ((BATCH + NUM_PORTS - 1) > ((2 ** STEP_WIDTH) - 1)) begin : g_bad_batch
    $error("difftest_step_batcher: BATCH + NUM_PORTS - 1 exceeds step_out range");
  end
  if (BATCH < 1) begin : g_bad_batch_min
    $error("difftest_step_batcher: BATCH must be at least 1");
  end
  if (CNT_W > STEP_WIDTH) begin : g_bad_cnt
    $error("difftest_step_batcher: commit count wider than step_out");
  end

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] acc_q, acc_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [63:0]           exit_q, exit_d;
  logic [63:0]           code_q, code_d;
  logic                  exited_q, exited_d;

  logic [CNT_W-1:0]      inc;
  logic [STEP_WIDTH:0]   sum;
  logic                  exit_seen;
  logic                  timeout_hit;
  logic                  emit;

  difftest_commit_popcount #(
    .NUM_PORTS (NUM_PORTS),
    .CNT_W     (CNT_W)
  ) u_popcount (
    .valid_i (commit_valid),
    .count_o (inc)
  );

  // Emit decision, highest priority first: exit, flush, disable, threshold, timeout.
  always_comb begin
    sum         = {1'b0, acc_q} + (STEP_WIDTH + 1)'(inc);
    exit_seen   = (exit_in != '0);
    timeout_hit = (TIMEOUT != 0) && (acc_q != '0) && (timer_q == TMR_LAST);
    emit        = exit_seen || flush_req || !enable || (sum >= BATCH_L) || timeout_hit;
  end

  // Next-state and output decisions for the RUN / EXIT_WAIT / EXITED lifecycle.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    timer_d  = timer_q;
    step_d   = '0;
    exit_d   = exit_q;
    code_d   = code_q;
    exited_d = exited_q;
    unique case (state_q)
      RUN: begin
        if (emit) begin
          // A zero sum naturally leaves step_out at 0.
          step_d  = sum[STEP_WIDTH-1:0];
          acc_d   = '0;
          timer_d = '0;
        end else begin
          acc_d = sum[STEP_WIDTH-1:0];
          // Idle timer only runs while commits are pending and none arrive.
          if ((inc != '0) || (acc_q == '0)) begin
            timer_d = '0;
          end else if (timer_q != TMR_LAST) begin
            timer_d = timer_q + 1'b1;
          end
        end
        if (exit_seen) begin
          state_d = EXIT_WAIT;
          code_d  = exit_in;
        end
      end
      EXIT_WAIT: begin
        // The final step is already out; present the exit code one cycle later.
        exit_d   = code_q;
        exited_d = 1'b1;
        acc_d    = '0;
        timer_d  = '0;
        state_d  = EXITED;
      end
      EXITED: begin
        // Terminal: everything held, step_out stays 0.
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      acc_q    <= '0;
      timer_q  <= '0;
      step_q   <= '0;
      exit_q   <= '0;
      code_q   <= '0;
      exited_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      exit_q   <= exit_d;
      code_q   <= code_d;
      exited_q <= exited_d;
    end
  end

  assign step_out = step_q;
  assign exit_out = exit_q;
  assign pending  = acc_q;
  assign exited   = exited_q;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Scoreboard bench for difftest_step_batcher (default parameters plus a TIMEOUT=0 instance).
// Latency: expectations are pushed one edge after their inputs and checked at the next falling edge.
// Backpressure: n/a; the DUT has none.
module tb_difftest_step_batcher;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  cv;
  logic        fl;
  logic [63:0] ex;

  logic [7:0]  step1, pend1, step0, pend0;
  logic [63:0] exit1, exit0;
  logic        exd1, exd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  step;
    logic [7:0]  pend;
    logic [63:0] ex;
    logic        exd;
    bit          chk0;
    logic [7:0]  step0;
    logic [7:0]  pend0;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  difftest_step_batcher #(
    .NUM_PORTS(4), .STEP_WIDTH(8), .BATCH(32), .TIMEOUT(16)
  ) dut (
    .clock(clk), .reset(rst_n), .enable(en), .commit_valid(cv), .flush_req(fl),
    .exit_in(ex), .step_out(step1), .exit_out(exit1), .pending(pend1), .exited(exd1)
  );

  difftest_step_batcher #(
    .NUM_PORTS(4), .STEP_WIDTH(8), .BATCH(32), .TIMEOUT(0)
  ) dut_nto (
    .clock(clk), .reset(rst_n), .enable(en), .commit_valid(cv), .flush_req(fl),
    .exit_in(ex), .step_out(step0), .exit_out(exit0), .pending(pend0), .exited(exd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; pop and compare.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("step_out", 64'(step1), 64'(e.step));
      chk("pending",  64'(pend1), 64'(e.pend));
      chk("exit_out", exit1,      e.ex);
      chk("exited",   64'(exd1),  64'(e.exd));
      if (e.chk0) begin
        chk("nto_step_out", 64'(step0), 64'(e.step0));
        chk("nto_pending",  64'(pend0), 64'(e.pend0));
      end
    end
  end

  // Apply one cycle of inputs; after the edge, push what the outputs must be.
  task automatic drive(input logic [3:0] c, input logic f, input logic [63:0] x,
                       input logic [7:0] es, input logic [7:0] ep,
                       input logic [63:0] eex, input logic eexd,
                       input bit c0, input logic [7:0] es0, input logic [7:0] ep0);
    exp_t n;
    cv = c;
    fl = f;
    ex = x;
    @(posedge clk);
    #1;
    n.step = es; n.pend = ep; n.ex = eex; n.exd = eexd;
    n.chk0 = c0; n.step0 = es0; n.pend0 = ep0;
    exp_q.push_back(n);
  endtask

  task automatic cyc(input logic [3:0] c, input logic f, input logic [63:0] x,
                     input logic [7:0] es, input logic [7:0] ep,
                     input logic [63:0] eex, input logic eexd);
    drive(c, f, x, es, ep, eex, eexd, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic cyc0(input logic [3:0] c, input logic f,
                      input logic [7:0] es, input logic [7:0] ep,
                      input logic [7:0] es0, input logic [7:0] ep0);
    drive(c, f, 64'd0, es, ep, 64'd0, 1'b0, 1'b1, es0, ep0);
  endtask

  task automatic async_reset();
    cv = 4'h0; fl = 1'b0; ex = 64'd0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_step_out", 64'(step1), 64'd0);
    chk("rst_pending",  64'(pend1), 64'd0);
    chk("rst_exit_out", exit1,      64'd0);
    chk("rst_exited",   64'(exd1),  64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; cv = 4'h0; fl = 1'b0; ex = 64'd0;
    #2;
    chk("init_step_out", 64'(step1), 64'd0);
    chk("init_pending",  64'(pend1), 64'd0);
    chk("init_exit_out", exit1,      64'd0);
    chk("init_exited",   64'(exd1),  64'd0);
    chk("init_nto_step", 64'(step0), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Timeout: a single commit is forced out 16 edges after it was captured;
    // the TIMEOUT=0 instance keeps it pending until the flush.
    cyc0(4'h1, 1'b0, 8'd0, 8'd1, 8'd0, 8'd1);
    for (int i = 0; i < 15; i++) cyc0(4'h0, 1'b0, 8'd0, 8'd1, 8'd0, 8'd1);
    cyc0(4'h0, 1'b0, 8'd1, 8'd0, 8'd0, 8'd1);
    repeat (2) cyc0(4'h0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd1);
    cyc0(4'h0, 1'b1, 8'd0, 8'd0, 8'd1, 8'd0);

    // Threshold: eight full cycles reach exactly 32.
    for (int i = 0; i < 7; i++) cyc(4'hF, 1'b0, 64'd0, 8'd0, 8'(4 * (i + 1)), 64'd0, 1'b0);
    cyc(4'hF, 1'b0, 64'd0, 8'd32, 8'd0, 64'd0, 1'b0);
    cyc(4'h0, 1'b0, 64'd0, 8'd0,  8'd0, 64'd0, 1'b0);

    // Overshoot: 31 carried, then +2 crosses the threshold at 33.
    for (int i = 0; i < 7; i++) cyc(4'hF, 1'b0, 64'd0, 8'd0, 8'(4 * (i + 1)), 64'd0, 1'b0);
    cyc(4'h7, 1'b0, 64'd0, 8'd0,  8'd31, 64'd0, 1'b0);
    cyc(4'h3, 1'b0, 64'd0, 8'd33, 8'd0,  64'd0, 1'b0);
    cyc(4'h0, 1'b0, 64'd0, 8'd0,  8'd0,  64'd0, 1'b0);

    // Pass-through: dropping enable emits acc 5 plus 2, then per-cycle counts.
    cyc(4'hF, 1'b0, 64'd0, 8'd0, 8'd4, 64'd0, 1'b0);
    cyc(4'h1, 1'b0, 64'd0, 8'd0, 8'd5, 64'd0, 1'b0);
    en = 1'b0;
    cyc(4'h3, 1'b0, 64'd0, 8'd7, 8'd0, 64'd0, 1'b0);
    cyc(4'hF, 1'b0, 64'd0, 8'd4, 8'd0, 64'd0, 1'b0);
    cyc(4'h5, 1'b0, 64'd0, 8'd2, 8'd0, 64'd0, 1'b0);
    cyc(4'h0, 1'b0, 64'd0, 8'd0, 8'd0, 64'd0, 1'b0);
    en = 1'b1;
    cyc(4'h1, 1'b0, 64'd0, 8'd0, 8'd1, 64'd0, 1'b0);
    cyc(4'h2, 1'b1, 64'd0, 8'd2, 8'd0, 64'd0, 1'b0);

    // Async reset mid-batch at acc=20: nothing leaks out afterwards.
    for (int i = 0; i < 5; i++) cyc(4'hF, 1'b0, 64'd0, 8'd0, 8'(4 * (i + 1)), 64'd0, 1'b0);
    async_reset();
    repeat (3) cyc(4'h0, 1'b0, 64'd0, 8'd0, 8'd0, 64'd0, 1'b0);

    // Good exit: final step 12 one cycle before the exit code, then frozen.
    cyc(4'hF, 1'b0, 64'd0, 8'd0, 8'd4,  64'd0, 1'b0);
    cyc(4'hF, 1'b0, 64'd0, 8'd0, 8'd8,  64'd0, 1'b0);
    cyc(4'h3, 1'b0, 64'd0, 8'd0, 8'd10, 64'd0, 1'b0);
    cyc(4'h3, 1'b0, ONES,  8'd12, 8'd0, 64'd0, 1'b0);
    cyc(4'hF, 1'b1, ONES,  8'd0,  8'd0, ONES,  1'b1);
    repeat (3) cyc(4'hF, 1'b1, 64'h5, 8'd0, 8'd0, ONES, 1'b1);

    // Error exit together with a flush: one emit, code latched even after exit_in drops.
    async_reset();
    cyc(4'h1, 1'b0, 64'd0,    8'd0, 8'd1, 64'd0,    1'b0);
    cyc(4'h0, 1'b1, 64'h1234, 8'd1, 8'd0, 64'd0,    1'b0);
    cyc(4'h0, 1'b0, 64'd0,    8'd0, 8'd0, 64'h1234, 1'b1);
    cyc(4'hF, 1'b0, 64'd0,    8'd0, 8'd0, 64'h1234, 1'b1);

    cv = 4'h0; fl = 1'b0; ex = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
